// File: rtl/pll_pocket_rstctl_if.sv
// pll_pocket_rstctl_if: PLL lock input and the sequencer's reset/status outputs
// master (sequencer): in locked; out pll_rst, rst_out, ready, retries[2:0], fail, loss_cnt[7:0]
// slave (PLL/consumer side): mirror of master
interface pll_pocket_rstctl_if;
  logic       locked;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic [2:0] retries;
  logic       fail;
  logic [7:0] loss_cnt;
  modport master (input locked, output pll_rst, rst_out, ready, retries, fail, loss_cnt);
  modport slave (output locked, input pll_rst, rst_out, ready, retries, fail, loss_cnt);
endinterface

// File: rtl/pll_pocket_rstctl.sv
// pll_pocket_rstctl: PLL reset pulse, lock wait with timeout/retry, lock qualification, clean rst_out release
// ports: clk, rst (sync, active high); bus.master: locked in (async), pll_rst, rst_out, ready, retries, fail, loss_cnt out
// PLL_RSTCTL_LOSSCNT_EN defined: loss_cnt counts RUN loss-of-lock events (saturating); undefined: loss_cnt is 0
module pll_pocket_rstctl #(
  parameter int PULSE_LEN  = 16,
  parameter int STABLE_LEN = 1024,
  parameter int TMO_W      = 20,
  parameter int MAX_RETRY  = 7
) (
  input logic clk,
  input logic rst,
  pll_pocket_rstctl_if.master bus
);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int SW = $clog2(STABLE_LEN + 1);
  typedef enum logic [2:0] {PULSE, WAIT, STABLE, RUN, FAIL} state_t;
  state_t state, nxt;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [TMO_W-1:0] tcnt, tcnt_n;
  logic [2:0] retries_n;
  logic l1, locked_s;
  always_comb begin
    nxt = state;
    pcnt_n = '0;
    scnt_n = scnt;
    tcnt_n = tcnt;
    retries_n = bus.retries;
    unique case (state)
      PULSE: begin
        pcnt_n = pcnt + PW'(1);
        tcnt_n = '0;
        nxt = pcnt == PW'(PULSE_LEN - 1) ? WAIT : PULSE;
      end
      WAIT:
        if (locked_s) begin
          nxt = STABLE;
          scnt_n = '0;
        end else if (&tcnt) begin
          retries_n = bus.retries + 3'd1;
          nxt = retries_n >= 3'(MAX_RETRY) ? FAIL : PULSE;
        end else tcnt_n = tcnt + TMO_W'(1);
      STABLE:
        if (!locked_s) nxt = WAIT;
        else begin
          scnt_n = scnt + SW'(1);
          if (scnt == SW'(STABLE_LEN - 1)) begin
            nxt = RUN;
            retries_n = '0;
          end
        end
      RUN: nxt = locked_s ? RUN : PULSE;
      FAIL: nxt = FAIL;
      default: nxt = PULSE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PULSE;
      pcnt <= '0;
      scnt <= '0;
      tcnt <= '0;
      l1 <= 1'b0;
      locked_s <= 1'b0;
      bus.pll_rst <= 1'b1;
      bus.rst_out <= 1'b1;
      bus.ready <= 1'b0;
      bus.retries <= '0;
      bus.fail <= 1'b0;
    end else begin
      state <= nxt;
      pcnt <= pcnt_n;
      scnt <= scnt_n;
      tcnt <= tcnt_n;
      l1 <= bus.locked;
      locked_s <= l1;
      bus.pll_rst <= nxt == PULSE || nxt == FAIL;
      bus.rst_out <= nxt != RUN;
      bus.ready <= nxt == RUN;
      bus.retries <= retries_n;
      bus.fail <= nxt == FAIL;
    end
  end
`ifdef PLL_RSTCTL_LOSSCNT_EN
  logic [7:0] loss;
  always_ff @(posedge clk) begin
    if (rst) loss <= '0;
    else if (state == RUN && nxt == PULSE && loss != 8'hff) loss <= loss + 8'd1;
  end
  assign bus.loss_cnt = loss;
`else
  assign bus.loss_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_pll_pocket_rstctl.sv
// tb_pll_pocket_rstctl: randomized lock/glitch/reset stimulus checked every cycle against a phase-level model
module tb_pll_pocket_rstctl;
  localparam int PL = 4, SL = 8, TW = 6, MR = 2;
  localparam int BUDGET = 2 ** TW;
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0, n_err = 0;
  pll_pocket_rstctl_if bus ();
  pll_pocket_rstctl #(.PULSE_LEN(PL), .STABLE_LEN(SL), .TMO_W(TW), .MAX_RETRY(MR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // reference model: phase plus elapsed-time bookkeeping, advanced on each rising edge
  int ph, age, waited, hi_run, m_retries, m_loss;
  bit s1, s2, seen, m_valid = 0;
  always @(posedge clk) begin
    if (rst) begin
      ph = PH_PULSE; age = 0; waited = 0; hi_run = 0; m_retries = 0; m_loss = 0;
      s1 = 0; s2 = 0; m_valid = 1;
    end else begin
      seen = s2;
      s2 = s1;
      s1 = bus.locked;
      case (ph)
        PH_PULSE: begin
          age++;
          if (age == PL) begin ph = PH_WAIT; waited = 0; end
        end
        PH_WAIT:
          if (seen) begin ph = PH_STABLE; hi_run = 0; end
          else if (waited == BUDGET - 1) begin
            m_retries++;
            if (m_retries < MR) begin ph = PH_PULSE; age = 0; end
            else ph = PH_FAIL;
          end else waited++;
        PH_STABLE:
          if (!seen) ph = PH_WAIT;
          else begin
            hi_run++;
            if (hi_run == SL) begin ph = PH_RUN; m_retries = 0; end
          end
        PH_RUN:
          if (!seen) begin
            ph = PH_PULSE; age = 0;
            if (m_loss < 255) m_loss++;
          end
        default: ;
      endcase
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int draw_delay(input int mode);
    case (mode)
      0: return $urandom_range(0, 30);
      1: return 1000000;
      2: return $urandom_range(50, 130);
      default: return $urandom_range(0, 20);
    endcase
  endfunction
  int dly, low_left;
  initial begin
    bus.locked = 1'b0;
    dly = 0;
    low_left = 0;
    for (int ep = 0; ep < 40; ep++) begin
      int mode, len;
      mode = ep % 4;
      len = mode == 1 ? 1200 : 400;
      rst = 1'b1;
      for (int c = -int'($urandom_range(1, 3)); c < len; c++) begin
        @(negedge clk);
        if (m_valid) begin
          check("pll_rst", 32'(bus.pll_rst), 32'(ph == PH_PULSE || ph == PH_FAIL));
          check("rst_out", 32'(bus.rst_out), 32'(ph != PH_RUN));
          check("ready", 32'(bus.ready), 32'(ph == PH_RUN));
          check("fail", 32'(bus.fail), 32'(ph == PH_FAIL));
          check("retries", 32'(bus.retries), 32'(m_retries));
`ifdef PLL_RSTCTL_LOSSCNT_EN
          check("loss_cnt", 32'(bus.loss_cnt), 32'(m_loss));
`else
          check("loss_cnt", 32'(bus.loss_cnt), 32'd0);
`endif
        end
        rst = c < 0 || (mode == 2 && c == 20) || $urandom_range(0, 999) == 0;
        if (bus.pll_rst) begin
          bus.locked = 1'b0;
          dly = draw_delay(mode);
          low_left = 0;
        end else if (dly > 0) begin
          dly--;
          bus.locked = 1'b0;
        end else if (low_left > 0) begin
          low_left--;
          bus.locked = 1'b0;
        end else begin
          bus.locked = 1'b1;
          if (mode == 3 && $urandom_range(0, 29) == 0) low_left = $urandom_range(1, 4);
          else if ($urandom_range(0, 199) == 0) low_left = 2;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
